gb_host_bridge: RTL and testbench



---
 rtl/gb_pkg.sv | 13 +
 rtl/gb_host_bridge.sv | 66 ++++++
 tb/tb_gb_host_bridge.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gb_pkg.sv
// gb_pkg: shared FSM state codes and read-latency limits for the ghostbus host bridge
package gb_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;
  localparam int CNT_W = 4;
  localparam int RD_LAT_MAX = (1 << CNT_W) - 1;
  function automatic bit rd_lat_ok(input int lat);
    return lat >= 1 && lat <= RD_LAT_MAX;
  endfunction
endpackage

// File: rtl/gb_host_bridge.sv
// gb_host_bridge: single-outstanding host request/response to ghostbus strobe bridge
module gb_host_bridge import gb_pkg::*; #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          busy,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_rdata
);
  // an out-of-range latency falls back to the minimum of one cycle
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(rd_lat_ok(RD_LAT) ? RD_LAT - 1 : 0);
  logic [2:0] state, nxt;
  logic [CNT_W-1:0] cnt;
  assign req_ready  = rst_n && state == S_IDLE;
  assign busy       = state != S_IDLE;
  assign gb_we      = state == S_WR;
  assign gb_re      = state == S_RD;
  assign resp_valid = state == S_RESP;
  // next state: every transaction returns through IDLE for at least one cycle
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE: nxt = req_valid ? (req_write ? S_WR : S_RD) : S_IDLE;
      S_RD:   nxt = S_WAIT;
      S_WAIT: nxt = cnt == '0 ? S_RESP : S_WAIT;
      S_RESP: nxt = resp_ready ? S_IDLE : S_RESP;
      default: nxt = S_IDLE;
    endcase
  end
  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  // latch request address/data on the accepting edge and hold them afterwards
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gb_addr  <= '0;
      gb_wdata <= '0;
    end else if (state == S_IDLE && req_valid) begin
      gb_addr  <= req_addr;
      gb_wdata <= req_wdata;
    end
  // read latency countdown, loaded during the read strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (state == S_RD) cnt <= LAT_LD;
    else if (state == S_WAIT && cnt != '0) cnt <= cnt - CNT_W'(1);
  // capture bus read data when the countdown expires; kept until the next capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) resp_rdata <= '0;
    else if (state == S_WAIT && cnt == '0) resp_rdata <= gb_rdata;
endmodule

// File: tb/tb_gb_host_bridge.sv
// tb_gb_host_bridge: directed and random checks of two bridges (RD_LAT=1 and RD_LAT=3) against a memory reference
module tb_gb_host_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic rdy [2], rv [2], bsy [2], we [2], re [2];
  logic [23:0] gba [2];
  logic [31:0] gbw [2], rdat [2];
  logic [31:0] gbr [2] = '{default: 32'h0};
  int lat_of [2] = '{1, 3};
  int n_tests = 0, n_fail = 0;
  logic [31:0] fab [logic [24:0]];
  logic [31:0] ref_mem [logic [24:0]];
  int left [2];
  bit act [2];
  logic [23:0] paddr [2];
  logic o_ready, o_rvalid, o_busy, o_we, o_re;
  logic [23:0] o_addr;
  logic [31:0] o_wdata, o_rdata;

  always #5 clk = ~clk;

  gb_host_bridge #(.AW(24), .DW(32), .RD_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rdy[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[0]), .resp_ready(resp_ready & ~sel), .resp_rdata(rdat[0]),
    .busy(bsy[0]), .gb_addr(gba[0]), .gb_wdata(gbw[0]), .gb_we(we[0]), .gb_re(re[0]),
    .gb_rdata(gbr[0]));
  gb_host_bridge #(.AW(24), .DW(32), .RD_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rdy[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[1]), .resp_ready(resp_ready & sel), .resp_rdata(rdat[1]),
    .busy(bsy[1]), .gb_addr(gba[1]), .gb_wdata(gbw[1]), .gb_we(we[1]), .gb_re(re[1]),
    .gb_rdata(gbr[1]));

  assign o_ready  = rdy[sel];
  assign o_rvalid = rv[sel];
  assign o_busy   = bsy[sel];
  assign o_we     = we[sel];
  assign o_re     = re[sel];
  assign o_addr   = gba[sel];
  assign o_wdata  = gbw[sel];
  assign o_rdata  = rdat[sel];

  function automatic logic [31:0] fab_rd(input logic [24:0] key);
    return fab.exists(key) ? fab[key] : 32'h0;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [24:0] key);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  // ghostbus fabric: stores writes, returns read data exactly RD_LAT cycles after the strobe, wrong data otherwise
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (we[k]) fab[{1'(k), gba[k]}] = gbw[k];
      if (re[k]) begin
        act[k] = 1'b1;
        left[k] = lat_of[k] - 1;
        paddr[k] = gba[k];
      end else if (act[k]) begin
        if (left[k] == 0) act[k] = 1'b0;
        else left[k]--;
      end
      gbr[k] <= act[k] ? (left[k] == 0 ? fab_rd({1'(k), paddr[k]}) : ~fab_rd({1'(k), paddr[k]})) : 32'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pick(input logic s);
    sel = s;
    #1;
    for (int n = 0; n < 50 && !o_ready; n++) @(negedge clk);
    if (!o_ready) chk("ready_timeout", o_ready, 1);
  endtask

  task automatic wr(input logic s, input logic [23:0] a, input logic [31:0] d);
    pick(s);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("wr_we", o_we, 1);
    chk("wr_re", o_re, 0);
    chk("wr_addr", o_addr, a);
    chk("wr_data", o_wdata, d);
    chk("wr_ready_busy", {o_ready, o_busy}, 2'b01);
    ref_mem[{s, a}] = d;
    @(negedge clk);
    chk("wr_done", {o_we, o_ready, o_busy, o_rvalid}, 4'b0100);
  endtask

  task automatic rd(input logic s, input logic [23:0] a, input int hold);
    logic [31:0] exp;
    int k, nre, nwe;
    pick(s);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = $urandom;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    exp = ref_rd({s, a});
    k = 1; nre = int'(o_re); nwe = int'(o_we);
    chk("rd_strobe_addr", {o_re, o_addr}, {1'b1, a});
    while (!o_rvalid && k < 40) begin
      @(negedge clk);
      k++;
      nre += int'(o_re);
      nwe += int'(o_we);
    end
    chk("rd_latency", k, 2 + lat_of[s]);
    chk("rd_data", o_rdata, exp);
    chk("rd_re_count", nre, 1);
    chk("rd_we_count", nwe, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rd_hold", {o_rvalid, o_ready, o_re, o_rdata}, {3'b100, exp});
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    chk("rd_done", {o_rvalid, o_ready, o_busy}, 3'b010);
    chk("rd_kept", o_rdata, exp);
  endtask

  initial begin
    #3;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_ctrl", {o_ready, o_rvalid, o_busy, o_we, o_re}, 5'b0);
      chk("rst_data", {o_addr, o_wdata, o_rdata}, 88'h0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready0", rdy[0], 1);
    chk("rel_ready1", rdy[1], 1);
    @(negedge clk);
    // write then read back through RD_LAT=1
    wr(0, 24'h000100, 32'h5A);
    rd(0, 24'h000100, 0);
    chk("wr_rd_value", o_rdata, 32'h5A);
    // preloaded fabric
    for (int i = 0; i < 16; i++) begin
      fab[{1'b0, 24'(24'h100 + i)}] = 32'(32'h81 + i);
      ref_mem[{1'b0, 24'(24'h100 + i)}] = 32'(32'h81 + i);
    end
    rd(0, 24'h000105, 0);
    chk("preload_value", o_rdata, 32'h86);
    // response backpressure
    rd(0, 24'h000103, 10);
    chk("bp_value", o_rdata, 32'h84);
    // RD_LAT=3 with wrong data before the valid cycle
    fab[{1'b1, 24'h000300}] = 32'hDEADBEEF;
    ref_mem[{1'b1, 24'h000300}] = 32'hDEADBEEF;
    rd(1, 24'h000300, 2);
    chk("lat3_value", o_rdata, 32'hDEADBEEF);
    // back-to-back writes with req_valid held high
    pick(0);
    req_valid = 1'b1; req_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 24'(24'h200 + i);
      req_wdata = 32'(32'hB0 + i);
      chk("b2b_ready", o_ready, 1);
      @(posedge clk); @(negedge clk);
      chk("b2b_we", {o_we, o_addr, o_wdata}, {1'b1, 24'(24'h200 + i), 32'(32'hB0 + i)});
      ref_mem[{1'b0, 24'(24'h200 + i)}] = 32'(32'hB0 + i);
      @(posedge clk); @(negedge clk);
      chk("b2b_gap", {o_we, o_rvalid, o_ready}, 3'b001);
      if (i == 3) req_valid = 1'b0;
    end
    rd(0, 24'h000202, 0);
    // randomized traffic on both bridges
    for (int n = 0; n < 24; n++) begin
      logic s;
      logic [23:0] a;
      s = 1'($urandom_range(0, 1));
      a = 24'(24'h400 + $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) wr(s, a, $urandom);
      else rd(s, a, $urandom_range(0, 3));
    end
    // reset during the WAIT state of an RD_LAT=3 read
    pick(1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000300;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", {o_busy, o_re, o_rvalid}, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {o_re, o_rvalid, o_busy, o_ready, o_we}, 5'b0);
    chk("mid_rst_rdata", o_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", {o_ready, o_busy}, 2'b10);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_no_resp", {o_rvalid, o_busy, o_re}, 3'b000);
    end
    rd(1, 24'h000300, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
